// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory / lock arbiter.
package mem_arbiter_pkg;

    localparam int LOCK_W    = 4;
    localparam int NUM_LOCKS = 16;
    localparam int ADR_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } mem_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] owner;
    } lock_entry_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    logic [$clog2(N)-1:0] ptr;

    // Walk downwards so the requester closest to ptr is written last and wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j]) begin
                idx = ($clog2(N))'(j);
                any = 1'b1;
            end
        end
        if (any) grant[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && any) begin
            if (idx == ($clog2(N))'(N - 1)) ptr <= '0;
            else                             ptr <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises per-core memory and lock requests onto one main_mem port.
// Lock table is built only when MEM_ARBITER_LOCK_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int C = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [C-1:0]      main_mem_read_request,
    input  logic [C-1:0]      main_mem_write_request,
    input  logic [C*16-1:0]   main_mem_read_adr,
    input  logic [C*16-1:0]   main_mem_write_adr,
    input  logic [C*16-1:0]   main_mem_write_dat,
    output logic [15:0]       mem_adr,
    output logic              mem_we,
    output logic [15:0]       mem_wdat,
    input  logic [15:0]       mem_rdat,
    output logic [15:0]       main_mem_dat,
    output logic [C-1:0]      main_mem_ac,
    input  logic [C*4-1:0]    lock_adr,
    input  logic [C-1:0]      lock_en,
    input  logic [C-1:0]      unlock_en,
    output logic [C-1:0]      lock_ac
);

    localparam int CW = $clog2(C);

    mem_state_t state, state_nxt;

    logic [C-1:0]  mem_req;
    logic [C-1:0]  mem_gnt;
    logic [CW-1:0] mem_idx;
    logic          mem_any;
    logic [CW-1:0] win;
    logic          win_we;
    logic          sel_we;
    logic [15:0]   sel_adr;
    logic [15:0]   sel_dat;

    assign mem_req = main_mem_read_request | main_mem_write_request;

    rr_arbiter #(.N(C)) u_mem_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (mem_req),
        .advance (state == IDLE),
        .grant   (mem_gnt),
        .idx     (mem_idx),
        .any     (mem_any)
    );

    // A core's write outranks its own read; the read waits for a later slot.
    always_comb begin
        sel_we  = main_mem_write_request[mem_idx];
        sel_dat = main_mem_write_dat[mem_idx*ADR_W +: ADR_W];
        if (sel_we) sel_adr = main_mem_write_adr[mem_idx*ADR_W +: ADR_W];
        else        sel_adr = main_mem_read_adr[mem_idx*ADR_W +: ADR_W];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (mem_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mem_adr      <= '0;
            mem_we       <= 1'b0;
            mem_wdat     <= '0;
            main_mem_dat <= '0;
            main_mem_ac  <= '0;
            win          <= '0;
            win_we       <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_we      <= 1'b0;
            main_mem_ac <= '0;
            if (state == IDLE && mem_any) begin
                win      <= mem_idx;
                win_we   <= sel_we;
                mem_adr  <= sel_adr;
                mem_wdat <= sel_dat;
                mem_we   <= sel_we;
            end
            if (state == ISSUE) begin
                if (!win_we) main_mem_dat <= mem_rdat;
                main_mem_ac[win] <= 1'b1;
            end
        end
    end

`ifdef MEM_ARBITER_LOCK_EN

    lock_entry_t   lock_tbl [NUM_LOCKS];
    logic [C-1:0]  lock_elig;
    logic [C-1:0]  lock_gnt;
    logic [CW-1:0] lock_idx;
    logic          lock_any;

    // Free or already ours; a core being acked this cycle is masked off.
    always_comb begin
        lock_elig = '0;
        for (int c = 0; c < C; c++) begin
            if (lock_en[c] && !lock_ac[c]) begin
                if (!lock_tbl[lock_adr[c*LOCK_W +: LOCK_W]].valid ||
                    lock_tbl[lock_adr[c*LOCK_W +: LOCK_W]].owner == 3'(c))
                    lock_elig[c] = 1'b1;
            end
        end
    end

    rr_arbiter #(.N(C)) u_lock_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (lock_elig),
        .advance (1'b1),
        .grant   (lock_gnt),
        .idx     (lock_idx),
        .any     (lock_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOCKS; i++) lock_tbl[i] <= '0;
            lock_ac <= '0;
        end else begin
            for (int c = 0; c < C; c++) begin
                if (unlock_en[c] &&
                    lock_tbl[lock_adr[c*LOCK_W +: LOCK_W]].valid &&
                    lock_tbl[lock_adr[c*LOCK_W +: LOCK_W]].owner == 3'(c))
                    lock_tbl[lock_adr[c*LOCK_W +: LOCK_W]].valid <= 1'b0;
            end
            if (lock_any)
                lock_tbl[lock_adr[lock_idx*LOCK_W +: LOCK_W]] <=
                    {1'b1, 3'(lock_idx)};
            lock_ac <= lock_gnt;
        end
    end

`else

    logic unused_lock_inputs;
    assign unused_lock_inputs = ^{unlock_en, lock_adr};

    always_ff @(posedge clk) begin
        if (reset) lock_ac <= '0;
        else       lock_ac <= lock_en;
    end

`endif

endmodule
